// File: rtl/scc_fetch_queue.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue.
// Owns the fetch PC, issues sequential requests to a 1-cycle-latency
// instruction memory, and buffers returned words with their PCs for decode.
// A redirect flushes the queue and drops the response still in flight.
module scc_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              ADDR_INC = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [XLEN-1:0]          in_mem_addr,
  output logic                     in_mem_en,
  input  logic [XLEN-1:0]          in_mem,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int              PW      = $clog2(DEPTH);
  localparam logic [PW+1:0]   DEPTH_W = (PW+2)'(DEPTH);
  localparam logic [XLEN-1:0] INC_W   = XLEN'(ADDR_INC);

  logic            run_q;
  logic [XLEN-1:0] fetch_pc;
  logic            req_q;
  logic [XLEN-1:0] req_pc_q;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     level_q;
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic [PW+1:0]   committed;
  logic            push;
  logic            pop;

  // Issue only when every outstanding slot (stored + in flight) fits; a pop
  // in the same cycle is deliberately not credited so the queue cannot overflow.
  // The response landing during a redirect cycle is dropped by gating push;
  // no request issues in the redirect cycle, so nothing stale lands after it.
  always_comb begin
    committed = {1'b0, level_q} + {{(PW+1){1'b0}}, req_q};
    in_mem_en = run_q && !redirect_valid && (committed < DEPTH_W);
    push      = req_q && !redirect_valid;
    pop       = (level_q != '0) && out_ready && !redirect_valid;
  end

  assign in_mem_addr = fetch_pc;
  assign out_valid   = (level_q != '0);
  assign out_instr   = instr_mem[rd_ptr];
  assign out_pc      = pc_mem[rd_ptr];
  assign level       = level_q;

  // PC, request tracking, pointers and occupancy; redirect overrides all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q    <= 1'b0;
      fetch_pc <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
    end else begin
      run_q <= 1'b1;
      req_q <= in_mem_en;
      if (in_mem_en) begin
        req_pc_q <= fetch_pc;
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level_q  <= '0;
      end else begin
        if (in_mem_en) begin
          fetch_pc <= fetch_pc + INC_W;
        end
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (push && !pop) begin
          level_q <= level_q + (PW+1)'(1);
        end else if (pop && !push) begin
          level_q <= level_q - (PW+1)'(1);
        end
      end
    end
  end

  // Queue storage: capture the returned word with the PC that requested it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr] <= in_mem;
      pc_mem[wr_ptr]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_scc_fetch_queue.sv
// Bench for scc_fetch_queue: cycle tables per scenario, a free-running
// address/data scoreboard on the main instance, and hand sequences for the
// wrapping instance and the mid-run reset.
module tb_scc_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_mem_addr, in_mem, redirect_pc, out_instr, out_pc;
  logic        in_mem_en, redirect_valid, out_valid, out_ready;
  logic [2:0]  level;

  logic [31:0] w_in_mem_addr, w_in_mem, w_redirect_pc, w_out_instr, w_out_pc;
  logic        w_in_mem_en, w_redirect_valid, w_out_valid, w_out_ready;
  logic [2:0]  w_level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scc_fetch_queue dut (
    .clk(clk), .reset(reset),
    .in_mem_addr(in_mem_addr), .in_mem_en(in_mem_en), .in_mem(in_mem),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .level(level)
  );

  scc_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset),
    .in_mem_addr(w_in_mem_addr), .in_mem_en(w_in_mem_en), .in_mem(w_in_mem),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_instr(w_out_instr), .out_pc(w_out_pc),
    .out_ready(w_out_ready), .level(w_level)
  );

  // Memory models: word = address + 0x1000, one cycle after the request.
  always @(posedge clk) begin
    in_mem   <= in_mem_addr + 32'h1000;
    w_in_mem <= w_in_mem_addr + 32'h1000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected PCs pushed at request time, popped at each accept.
  logic [31:0] sb[$];
  logic [31:0] exp_addr;
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset) begin
      sb.delete();
      exp_addr = 32'h0;
    end else if (redirect_valid) begin
      chk("sb_en_in_redirect", {31'b0, in_mem_en}, 32'h0);
      sb.delete();
      exp_addr = redirect_pc;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got out_valid=1 out_pc=%h, expected no pending entry", out_pc);
        end else begin
          e = sb.pop_front();
          chk("sb_out_pc", out_pc, e);
          chk("sb_out_instr", out_instr, e + 32'h1000);
        end
      end
      if (in_mem_en) begin
        chk("sb_addr", in_mem_addr, exp_addr);
        sb.push_back(exp_addr);
        exp_addr = exp_addr + 32'h4;
      end
    end
  end

  typedef struct {
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    bit          en;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
    int          lvl;
  } vec_t;

  vec_t tbl[$];
  int   s_start[4];
  int   s_len[4];

  function automatic vec_t v(bit r, bit rd, logic [31:0] rpc, bit en, logic [31:0] a,
                             bit val, logic [31:0] pc, int l);
    vec_t t;
    t.ready = r; t.redir = rd; t.rpc = rpc; t.en = en; t.addr = a;
    t.valid = val; t.pc = pc; t.lvl = l;
    return t;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_en", {31'b0, in_mem_en}, 32'h0);
      chk("rst_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_level", {29'b0, level}, 32'h0);
    end
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic run_scn(input int s);
    int n;
    vec_t t;
    do_reset();
    n = 0;
    @(negedge clk);
    while (in_mem_en !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("s%0d_first_en_timeout", s), {31'b0, in_mem_en}, 32'h1);
    for (int i = 0; i < s_len[s]; i++) begin
      t = tbl[s_start[s] + i];
      if (i == 0) begin
        #1;
      end else begin
        @(posedge clk); #1;
      end
      out_ready = t.ready; redirect_valid = t.redir; redirect_pc = t.rpc;
      if (i != 0) @(negedge clk);
      chk($sformatf("s%0d_r%0d_en", s, i), {31'b0, in_mem_en}, {31'b0, t.en});
      if (t.en) chk($sformatf("s%0d_r%0d_addr", s, i), in_mem_addr, t.addr);
      chk($sformatf("s%0d_r%0d_valid", s, i), {31'b0, out_valid}, {31'b0, t.valid});
      if (t.valid) begin
        chk($sformatf("s%0d_r%0d_pc", s, i), out_pc, t.pc);
        chk($sformatf("s%0d_r%0d_instr", s, i), out_instr, t.pc + 32'h1000);
      end
      chk($sformatf("s%0d_r%0d_level", s, i), {29'b0, level}, t.lvl);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    w_out_ready = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = 32'h0;

    // Scenario 0: backpressure then drain, fetch resumes at 0x10.
    s_start[0] = tbl.size();
    tbl.push_back(v(0,0,0, 1,32'h00, 0,0,     0));
    tbl.push_back(v(0,0,0, 1,32'h04, 0,0,     0));
    tbl.push_back(v(0,0,0, 1,32'h08, 1,32'h0, 1));
    tbl.push_back(v(0,0,0, 1,32'h0C, 1,32'h0, 2));
    tbl.push_back(v(0,0,0, 0,0,      1,32'h0, 3));
    tbl.push_back(v(0,0,0, 0,0,      1,32'h0, 4));
    tbl.push_back(v(0,0,0, 0,0,      1,32'h0, 4));
    tbl.push_back(v(1,0,0, 0,0,      1,32'h0, 4));
    tbl.push_back(v(1,0,0, 1,32'h10, 1,32'h4, 3));
    tbl.push_back(v(1,0,0, 1,32'h14, 1,32'h8, 2));
    tbl.push_back(v(1,0,0, 1,32'h18, 1,32'hC, 2));
    tbl.push_back(v(1,0,0, 1,32'h1C, 1,32'h10,2));
    s_len[0] = tbl.size() - s_start[0];

    // Scenario 1: streaming at one instruction per cycle.
    s_start[1] = tbl.size();
    tbl.push_back(v(1,0,0, 1,32'h00, 0,0,     0));
    tbl.push_back(v(1,0,0, 1,32'h04, 0,0,     0));
    tbl.push_back(v(1,0,0, 1,32'h08, 1,32'h0, 1));
    tbl.push_back(v(1,0,0, 1,32'h0C, 1,32'h4, 1));
    tbl.push_back(v(1,0,0, 1,32'h10, 1,32'h8, 1));
    tbl.push_back(v(1,0,0, 1,32'h14, 1,32'hC, 1));
    s_len[1] = tbl.size() - s_start[1];

    // Scenario 2: redirect to 0x100 while the 0x8 response is in flight.
    s_start[2] = tbl.size();
    tbl.push_back(v(1,0,0,        1,32'h00,  0,0,       0));
    tbl.push_back(v(1,0,0,        1,32'h04,  0,0,       0));
    tbl.push_back(v(1,0,0,        1,32'h08,  1,32'h0,   1));
    tbl.push_back(v(1,1,32'h100,  0,0,       1,32'h4,   1));
    tbl.push_back(v(1,0,0,        1,32'h100, 0,0,       0));
    tbl.push_back(v(1,0,0,        1,32'h104, 0,0,       0));
    tbl.push_back(v(1,0,0,        1,32'h108, 1,32'h100, 1));
    tbl.push_back(v(1,0,0,        1,32'h10C, 1,32'h104, 1));
    s_len[2] = tbl.size() - s_start[2];

    // Scenario 3: redirect to 0x40 with a concurrent pop on a full queue.
    s_start[3] = tbl.size();
    tbl.push_back(v(0,0,0,       1,32'h00, 0,0,      0));
    tbl.push_back(v(0,0,0,       1,32'h04, 0,0,      0));
    tbl.push_back(v(0,0,0,       1,32'h08, 1,32'h0,  1));
    tbl.push_back(v(0,0,0,       1,32'h0C, 1,32'h0,  2));
    tbl.push_back(v(0,0,0,       0,0,      1,32'h0,  3));
    tbl.push_back(v(0,0,0,       0,0,      1,32'h0,  4));
    tbl.push_back(v(1,1,32'h40,  0,0,      1,32'h0,  4));
    tbl.push_back(v(1,0,0,       1,32'h40, 0,0,      0));
    tbl.push_back(v(1,0,0,       1,32'h44, 0,0,      0));
    tbl.push_back(v(1,0,0,       1,32'h48, 1,32'h40, 1));
    s_len[3] = tbl.size() - s_start[3];

    for (int s = 0; s < 4; s++) run_scn(s);

    // Wrap across 2^32 and asynchronous mid-stream reset.
    do_reset();
    n = 0;
    @(negedge clk);
    while (w_out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_valid_timeout", {31'b0, w_out_valid}, 32'h1);
    chk("wrap_pc0", w_out_pc, 32'hFFFF_FFF8);
    chk("wrap_instr0", w_out_instr, 32'h0000_0FF8);
    @(negedge clk);
    chk("wrap_valid1", {31'b0, w_out_valid}, 32'h1);
    chk("wrap_pc1", w_out_pc, 32'hFFFF_FFFC);
    chk("wrap_instr1", w_out_instr, 32'h0000_0FFC);
    @(negedge clk);
    chk("wrap_valid2", {31'b0, w_out_valid}, 32'h1);
    chk("wrap_pc2", w_out_pc, 32'h0000_0000);
    chk("wrap_instr2", w_out_instr, 32'h0000_1000);
    chk("main_valid_before_reset", {31'b0, out_valid}, 32'h1);

    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_w_valid", {31'b0, w_out_valid}, 32'h0);
    chk("midrst_level", {29'b0, level}, 32'h0);
    chk("midrst_w_level", {29'b0, w_level}, 32'h0);
    chk("midrst_en", {31'b0, in_mem_en}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    n = 0;
    @(negedge clk);
    while (w_in_mem_en !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("restart_en_timeout", {31'b0, w_in_mem_en}, 32'h1);
    chk("restart_addr0", w_in_mem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("restart_addr1", w_in_mem_addr, 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
